// File: rtl/mux_rr_stream.sv
// Registered N:1 stream mux, external-select or round-robin; 1-cycle latency.
// in_ready is granted to one channel only when the output register is empty or draining.
module mux_rr_stream #(
    parameter  int WIDTH  = 2,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [SEL_W-1:0] last_grant;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_vld;
    logic             ext_vld;
    logic [SEL_W-1:0] grant;
    logic             grant_vld;
    logic [WIDTH-1:0] grant_data;
    logic             load_en;
    int               idx;

    assign load_en = !out_valid || out_ready;

    // Walk the ring from the channel after last_grant; the first hit wins,
    // so last_grant itself is the lowest-priority candidate.
    always_comb begin
        rr_grant = last_grant;
        rr_vld   = 1'b0;
        idx      = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!rr_vld && in_valid[idx]) begin
                rr_grant = SEL_W'(idx);
                rr_vld   = 1'b1;
            end
        end
    end

    // Out-of-range sel values never match a channel, so they grant nothing.
    always_comb begin
        ext_vld = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) ext_vld = 1'b1;
        end
    end

    assign grant     = mode ? rr_grant : sel;
    assign grant_vld = mode ? rr_vld : ext_vld;

    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = load_en && grant_vld;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= SEL_W'(NUM_CH - 1);
        end else if (load_en) begin
            if (grant_vld) begin
                out_valid  <= 1'b1;
                out_data   <= grant_data;
                out_ch     <= grant;
                last_grant <= grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench for mux_rr_stream: default 4x2 instance and a 3x8 instance.
module tb_mux_rr_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4-channel, 2-bit instance
    logic       mode4 = 1'b0;
    logic [1:0] sel4 = '0;
    logic [7:0] data4 = '0;
    logic [3:0] valid4 = '0;
    logic [3:0] ready4;
    logic [1:0] out_data4;
    logic [1:0] out_ch4;
    logic       out_valid4;
    logic       out_ready4 = 1'b0;

    // 3-channel, 8-bit instance
    logic        mode3 = 1'b0;
    logic [1:0]  sel3 = '0;
    logic [23:0] data3 = '0;
    logic [2:0]  valid3 = '0;
    logic [2:0]  ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3 = 1'b0;

    mux_rr_stream dut4 (
        .clk(clk), .rst(rst), .mode(mode4), .sel(sel4),
        .in_data(data4), .in_valid(valid4), .in_ready(ready4),
        .out_data(out_data4), .out_ch(out_ch4), .out_valid(out_valid4),
        .out_ready(out_ready4)
    );

    mux_rr_stream #(.WIDTH(8), .NUM_CH(3)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
        .in_data(data3), .in_valid(valid3), .in_ready(ready3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which channel the rules select this cycle, or -1 for none.
    function automatic int pick(input int n, input logic md, input int s,
                                input logic [3:0] v, input int last);
        int c;
        if (!md) return (s < n && v[s]) ? s : -1;
        for (int k = 1; k <= n; k++) begin
            c = (last + k) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Reference state: what the output register should hold.
    logic       m4_vld, m3_vld;
    logic [1:0] m4_data;
    logic [7:0] m3_data;
    int         m4_ch, m4_last, m3_ch, m3_last;
    int         g4, g3;

    always_comb g4 = pick(4, mode4, int'(sel4), valid4, m4_last);
    always_comb g3 = pick(3, mode3, int'(sel3), {1'b0, valid3}, m3_last);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m4_vld <= 1'b0; m4_data <= '0; m4_ch <= 0; m4_last <= 3;
            m3_vld <= 1'b0; m3_data <= '0; m3_ch <= 0; m3_last <= 2;
        end else begin
            if (!m4_vld || out_ready4) begin
                if (g4 >= 0) begin
                    m4_vld <= 1'b1; m4_data <= data4[g4*2 +: 2];
                    m4_ch <= g4; m4_last <= g4;
                end else m4_vld <= 1'b0;
            end
            if (!m3_vld || out_ready3) begin
                if (g3 >= 0) begin
                    m3_vld <= 1'b1; m3_data <= data3[g3*8 +: 8];
                    m3_ch <= g3; m3_last <= g3;
                end else m3_vld <= 1'b0;
            end
        end
    end

    // Every-cycle comparison against the reference, away from the rising edge.
    always @(negedge clk) begin
        chk("m4_valid", 32'(out_valid4), 32'(m4_vld));
        chk("m4_data", 32'(out_data4), 32'(m4_data));
        chk("m4_ch", 32'(out_ch4), 32'(m4_ch));
        chk("m4_in_ready", 32'(ready4),
            ((!m4_vld || out_ready4) && g4 >= 0) ? (32'd1 << g4) : 32'd0);
        chk("m3_valid", 32'(out_valid3), 32'(m3_vld));
        chk("m3_data", 32'(out_data3), 32'(m3_data));
        chk("m3_ch", 32'(out_ch3), 32'(m3_ch));
        chk("m3_in_ready", 32'(ready3),
            ((!m3_vld || out_ready3) && g3 >= 0) ? (32'd1 << g3) : 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        step();
        chk("rst_valid", 32'(out_valid4), 0);
        chk("rst_data", 32'(out_data4), 0);
        chk("rst_ch", 32'(out_ch4), 0);
        step();
        rst = 1'b0;

        // 1: external select ch2
        mode4 = 1'b0; sel4 = 2'd2; valid4 = 4'b0100; data4 = 8'b00_11_00_00; out_ready4 = 1'b1;
        #1 chk("t1_in_ready", 32'(ready4), 32'b0100);
        step();
        chk("t1_valid", 32'(out_valid4), 1);
        chk("t1_data", 32'(out_data4), 3);
        chk("t1_ch", 32'(out_ch4), 2);

        // 2: selected channel idle
        sel4 = 2'd1; valid4 = 4'b1101;
        #1 chk("t2_in_ready", 32'(ready4), 0);
        step();
        chk("t2_valid", 32'(out_valid4), 0);
        chk("t2_data_hold", 32'(out_data4), 3);
        chk("t2_ch_hold", 32'(out_ch4), 2);

        // 3: round-robin fairness right after reset
        valid4 = 4'b0000;
        rst = 1'b1; #2 rst = 1'b0;
        mode4 = 1'b1; valid4 = 4'hF; data4 = 8'b11_10_01_00;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t3_ch", 32'(out_ch4), 32'(i % 4));
            chk("t3_data", 32'(out_data4), 32'(i % 4));
        end

        // 4: round-robin skipping idle channels
        valid4 = 4'b0010;
        step();
        chk("t4_ch1", 32'(out_ch4), 1);
        valid4 = 4'b1010;
        step(); chk("t4_ch3a", 32'(out_ch4), 3);
        step(); chk("t4_ch1b", 32'(out_ch4), 1);
        step(); chk("t4_ch3c", 32'(out_ch4), 3);

        // 5: backpressure holds the register, release loads with no bubble
        valid4 = 4'b0001; data4 = 8'b00_00_01_01;
        step();
        chk("t5_load_ch0", 32'(out_ch4), 0);
        out_ready4 = 1'b0; valid4 = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t5_in_ready_bp", 32'(ready4), 0);
            step();
            chk("t5_valid_hold", 32'(out_valid4), 1);
            chk("t5_data_hold", 32'(out_data4), 1);
            chk("t5_ch_hold", 32'(out_ch4), 0);
        end
        out_ready4 = 1'b1;
        #1 chk("t5_in_ready_rel", 32'(ready4), 32'b0010);
        step();
        chk("t5_no_bubble_valid", 32'(out_valid4), 1);
        chk("t5_no_bubble_ch", 32'(out_ch4), 1);

        // 6: async reset between edges while holding a word
        chk("t6_pre_valid", 32'(out_valid4), 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_async_valid", 32'(out_valid4), 0);
        chk("t6_async_data", 32'(out_data4), 0);
        chk("t6_async_ch", 32'(out_ch4), 0);
        #1 rst = 1'b0;
        step();
        chk("t6_first_rr", 32'(out_ch4), 0);
        valid4 = 4'b0000;

        // 7: three-channel instance
        mode3 = 1'b0; sel3 = 2'd3; valid3 = 3'b111; out_ready3 = 1'b1;
        data3 = {8'hC2, 8'hB1, 8'hA0};
        #1 chk("t7_in_ready_oor", 32'(ready3), 0);
        step();
        chk("t7_valid_oor", 32'(out_valid3), 0);
        mode3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t7_ch", 32'(out_ch3), 32'(i % 3));
            chk("t7_data", 32'(out_data3), 32'(8'hA0 + 8'h11 * (i % 3)));
        end
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
